// File: rtl/gene_line_assembler.sv
// FASTA byte-stream to fixed-width base line assembler feeding the line compressor.
// Optional GENE_CASE_FOLD_EN: fold stored lowercase letters to uppercase.
module gene_line_assembler #(
    parameter int         LINE_BASES = 100,
    parameter logic [7:0] PAD_CHAR   = 8'h41
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [LINE_BASES*8-1:0] line_data,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [6:0]              line_count,
    output logic                    line_last,
    output logic                    stream_done
);

    localparam logic [6:0] FULL_COUNT = 7'(LINE_BASES);
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_GT    = 8'h3E;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HEADER  = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    sol_q, sol_d;
    logic [6:0]              count_q, count_d;
    logic [LINE_BASES*8-1:0] buf_q, buf_d;
    logic                    line_valid_q, line_valid_d;
    logic                    line_last_q, line_last_d;
    logic                    stream_done_q, stream_done_d;
    logic                    in_ready_q, in_ready_d;

    logic                    accept_s;
    logic                    is_data_s;
    logic [7:0]              store_byte_s;
    logic [6:0]              count_inc_s;

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef GENE_CASE_FOLD_EN
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            fold_byte = b - 8'h20;
        end else begin
            fold_byte = b;
        end
`else
        fold_byte = b;
`endif
    endfunction

    // Next-state, buffer write and output-register computation.
    always_comb begin
        accept_s      = in_valid & in_ready_q;
        store_byte_s  = fold_byte(in_byte);
        count_inc_s   = count_q + 7'd1;
        is_data_s     = (in_byte != CHAR_LF) && (in_byte != CHAR_CR) &&
                        !((in_byte == CHAR_GT) && sol_q);
        state_d       = state_q;
        sol_d         = sol_q;
        count_d       = count_q;
        buf_d         = buf_q;
        line_last_d   = line_last_q;
        stream_done_d = accept_s & in_last;

        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    if (is_data_s) begin
                        for (int k = 0; k < LINE_BASES; k++) begin
                            if (count_q == 7'(k)) begin
                                buf_d[k*8 +: 8] = store_byte_s;
                            end else begin
                                buf_d[k*8 +: 8] = buf_q[k*8 +: 8];
                            end
                        end
                        count_d = count_inc_s;
                        sol_d   = 1'b0;
                        if (count_inc_s == FULL_COUNT) begin
                            state_d     = ST_HOLD;
                            line_last_d = in_last;
                        end else if (in_last) begin
                            state_d     = ST_HOLD;
                            line_last_d = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        if (in_byte == CHAR_LF) begin
                            sol_d = 1'b1;
                        end else begin
                            sol_d = sol_q;
                        end
                        // A closing stream flushes a partial line even on a dropped byte.
                        if (in_last && (count_q != 7'd0)) begin
                            state_d     = ST_HOLD;
                            line_last_d = 1'b1;
                        end else if (!in_last && (in_byte == CHAR_GT)) begin
                            state_d = ST_HEADER;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                    if (in_last) begin
                        sol_d = 1'b1;
                    end else begin
                        sol_d = sol_d;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HEADER: begin
                if (accept_s && in_last) begin
                    sol_d = 1'b1;
                    if (count_q != 7'd0) begin
                        state_d     = ST_HOLD;
                        line_last_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (accept_s && (in_byte == CHAR_LF)) begin
                    sol_d   = 1'b1;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_HOLD: begin
                if (line_valid_q && line_ready) begin
                    buf_d       = {LINE_BASES{PAD_CHAR}};
                    count_d     = 7'd0;
                    line_last_d = 1'b0;
                    state_d     = ST_COLLECT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        line_valid_d = (state_d == ST_HOLD);
        in_ready_d   = (state_d != ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            sol_q         <= 1'b1;
            count_q       <= 7'd0;
            buf_q         <= {LINE_BASES{PAD_CHAR}};
            line_valid_q  <= 1'b0;
            line_last_q   <= 1'b0;
            stream_done_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sol_q         <= sol_d;
            count_q       <= count_d;
            buf_q         <= buf_d;
            line_valid_q  <= line_valid_d;
            line_last_q   <= line_last_d;
            stream_done_q <= stream_done_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign line_data   = buf_q;
    assign line_valid  = line_valid_q;
    assign line_count  = count_q;
    assign line_last   = line_last_q;
    assign stream_done = stream_done_q;

endmodule

// File: tb/tb_gene_line_assembler.sv
// Randomized bench for gene_line_assembler against a stream-level reference model.
module tb_gene_line_assembler;

    localparam int LB = 100;
    localparam int W  = LB * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [W-1:0]  line_data;
    logic          line_valid;
    logic          line_ready = 1'b0;
    logic [6:0]    line_count;
    logic          line_last;
    logic          stream_done;

    gene_line_assembler #(.LINE_BASES(LB), .PAD_CHAR(8'h41)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .line_data(line_data),
        .line_valid(line_valid), .line_ready(line_ready), .line_count(line_count),
        .line_last(line_last), .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
        bit           last;
    } line_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stim[$];
    bit          ends_q[$];
    line_t       exp_q[$];
    logic [7:0]  m_cur[$];
    bit          m_sol = 1'b1;
    bit          m_hdr = 1'b0;
    logic [W-1:0] pad_line = {LB{8'h41}};

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_fold(input logic [7:0] b);
`ifdef GENE_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_cur.delete();
        m_sol = 1'b1;
        m_hdr = 1'b0;
    endtask

    task automatic emit_line(input bit lst);
        line_t l;
        l.data = pad_line;
        for (int k = 0; k < m_cur.size(); k++) l.data[k*8 +: 8] = m_cur[k];
        l.cnt  = m_cur.size();
        l.last = lst;
        exp_q.push_back(l);
        m_cur.delete();
    endtask

    // Parse the whole stream by the format rules and list the lines it should yield.
    task automatic model_stream(input bit with_last);
        logic [7:0] b;
        bit lst;
        ends_q.delete();
        for (int i = 0; i < stim.size(); i++) begin
            b   = stim[i];
            lst = with_last && (i == stim.size() - 1);
            ends_q.push_back(1'b0);
            if (m_hdr) begin
                if (b == 8'h0A) begin m_hdr = 1'b0; m_sol = 1'b1; end
            end else if (b == 8'h0A) m_sol = 1'b1;
            else if (b == 8'h0D) begin end
            else if (b == 8'h3E && m_sol) m_hdr = 1'b1;
            else begin m_cur.push_back(model_fold(b)); m_sol = 1'b0; end
            if (m_cur.size() == LB || (lst && m_cur.size() > 0)) begin
                emit_line(lst);
                ends_q[i] = 1'b1;
            end
            if (lst) begin m_hdr = 1'b0; m_sol = 1'b1; end
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_base();
        string p = "ACGTN";
        return p[$urandom_range(0, 3)];
    endfunction

    function automatic logic [7:0] rand_char();
        string lo = "acgtn";
        int r = $urandom_range(0, 99);
        if (r < 70) return rand_base();
        if (r < 80) return lo[$urandom_range(0, 4)];
        if (r < 88) return 8'h0A;
        if (r < 92) return 8'h0D;
        if (r < 96) return 8'h3E;
        return 8'h30 + 8'($urandom_range(0, 9));
    endfunction

    // Drive stim with random gaps and backpressure; check every output each cycle.
    task automatic run_stream(input bit with_last, input int valid_pct, input int ready_pct, input int hold);
        int  n = stim.size();
        int  idx = 0;
        int  cyc = 0;
        int  hold_cnt = 0;
        bit  rdy_seen = 1'b0;
        bit  lv_prev = 1'b0;
        bit  acc_last, acc_end;
        line_t l;
        model_stream(with_last);
        forever begin
            @(negedge clk);
            cyc++;
            acc_last = 1'b0;
            acc_end  = 1'b0;
            if (in_valid && rdy_seen) begin
                acc_end  = ends_q[idx];
                acc_last = in_last;
                idx++;
            end
            check_eq("stream_done", stream_done, acc_last);
            check_eq("in_ready_vs_hold", in_ready, !line_valid);
            if (acc_end) check_eq("line_latency", line_valid, 1'b1);
            if (lv_prev && line_ready) begin
                check_eq("line_release", line_valid, 1'b0);
                hold_cnt = 0;
            end
            if (line_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_line", 1'b1, 1'b0);
                end else begin
                    check_eq("line_data", line_data, exp_q[0].data);
                    check_eq("line_count", line_count, exp_q[0].cnt);
                    check_eq("line_last", line_last, exp_q[0].last);
                end
                hold_cnt++;
            end
            lv_prev    = line_valid;
            line_ready = 1'b0;
            if (line_valid && hold_cnt > hold && $urandom_range(0, 99) < ready_pct) begin
                line_ready = 1'b1;
                if (exp_q.size() > 0) l = exp_q.pop_front();
            end
            rdy_seen = in_ready;
            if (idx < n && $urandom_range(0, 99) < valid_pct) begin
                in_valid = 1'b1;
                in_byte  = stim[idx];
                in_last  = with_last && (idx == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_byte  = 8'($urandom_range(0, 255));
            end
            if (idx == n && !in_valid && exp_q.size() == 0 && !line_valid && !line_ready) break;
            if (cyc > 20 * n + 500) begin
                check_eq("timeout", 1'b1, 1'b0);
                break;
            end
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        line_ready = 1'b0;
        check_eq("lines_left", exp_q.size(), 0);
        exp_q.delete();
        stim.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_line_valid"}, line_valid, 1'b0);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_stream_done"}, stream_done, 1'b0);
        check_eq({tag, "_line_last"}, line_last, 1'b0);
        check_eq({tag, "_line_count"}, line_count, 7'd0);
        check_eq({tag, "_line_data"}, line_data, pad_line);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_reset", in_ready, 1'b1);

        for (int i = 0; i < 25; i++) push_str("ACGT");
        run_stream(1'b0, 100, 100, 0);

        push_str(">chr1 test\nGATTACA\n");
        run_stream(1'b1, 100, 100, 0);

        for (int i = 0; i < LB; i++) stim.push_back(rand_base());
        run_stream(1'b0, 100, 100, 20);

        for (int i = 0; i < 60; i++) stim.push_back(rand_base());
        push_str("\r\n");
        for (int i = 0; i < 40; i++) stim.push_back(rand_base());
        run_stream(1'b0, 80, 70, 2);

        for (int i = 0; i < 50; i++) stim.push_back(rand_base());
        run_stream(1'b0, 100, 100, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_midreset", in_ready, 1'b1);
        for (int i = 0; i < LB; i++) stim.push_back(rand_base());
        run_stream(1'b0, 100, 100, 0);

        push_str("acgtn");
        run_stream(1'b1, 100, 100, 0);

        for (int s = 0; s < 8; s++) begin
            int len = $urandom_range(1, 260);
            if (s == 0) push_str(">hdr x\n");
            for (int i = 0; i < len; i++) stim.push_back(rand_char());
            run_stream(1'b1, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gene_line_assembler.md
Name: gene_line_assembler

Overview:
- Upstream feeder for the 100-base line compressor.
- Accepts a FASTA-style ASCII byte stream one byte per cycle using valid/ready.
- Strips header lines, CR and LF; collects exactly LINE_BASES base characters into one flat buffer.
- Hands each full or final partial line downstream with a valid/ready handshake. Unused slots are pre-filled with PAD_CHAR.

Parameters:
- LINE_BASES, 100: bases per output line. The flat output width is LINE_BASES*8.
- PAD_CHAR, 8'h41: byte placed in every slot not written by input ('A').

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_byte  input  8  ASCII input byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  block accepts in_byte this cycle.
- in_last  input  1  qualifies the final byte of the stream, sampled with in_valid&in_ready.
- line_data  output  LINE_BASES*8  assembled line. The first accepted base is in [7:0]; base k is in [8k+7:8k].
- line_valid  output  1  line_data is valid and held stable until accepted.
- line_ready  input  1  downstream accepts the line.
- line_count  output  7  number of real bases in line_data, 1..LINE_BASES.
- line_last  output  1  this line contains the last base of the stream.
- stream_done  output  1  one-cycle pulse when in_last is consumed.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=COLLECT, sol (start-of-line flag)=1, count=0
  - every buffer slot=PAD_CHAR
  - line_valid=0, line_last=0, stream_done=0, in_ready=0
  - in_ready rises on the first clk edge after reset release.
- in_ready: 1 in COLLECT and HEADER, 0 in HOLD. It is registered and does not depend combinationally on in_valid.
- COLLECT, on an accepted byte:
  - 8'h0A: dropped; sol<=1.
  - 8'h0D: dropped; sol unchanged.
  - 8'h3E ('>') with sol=1: dropped; go to HEADER.
  - Any other byte: stored at slot count; count+1; sol<=0. A '>' with sol=0 is stored as data.
  - If count reaches LINE_BASES: go to HOLD, line_last=in_last.
  - If in_last is set on a dropped byte and count>0: go to HOLD with line_last=1.
  - If in_last is set and count=0: no line; stay in COLLECT.
- HEADER: every accepted byte is dropped.
  - 8'h0A: sol<=1, return to COLLECT.
  - in_last: return to COLLECT. If count>0, go to HOLD with line_last=1 instead.
  - A partial line count survives a header; header bytes never reset count.
- HOLD:
  - line_valid=1, line_count=count. line_data and line_count stay stable while line_ready=0.
  - On line_valid&line_ready: all slots <=PAD_CHAR, count<=0, line_valid<=0, line_last<=0, go to COLLECT.
  - in_ready returns next cycle, so there is no same-cycle bypass.
- stream_done: asserted for exactly one cycle, the cycle after the byte with in_last is accepted, regardless of any line still held.
- Latency: the LINE_BASES-th base accepted at edge N gives line_valid=1 after edge N. Throughput is LINE_BASES+1 cycles per line minimum.
- Count width: 7 bits is sufficient for LINE_BASES<=127. A larger LINE_BASES is unsupported.
- Reset mid-operation: all state is discarded immediately (async). Any partial line is lost and no line_valid is emitted.
- After stream_done the block accepts a new stream with sol=1.

Optional Feature:
- Macro: GENE_CASE_FOLD_EN.
- Defined: stored bytes in range 8'h61..8'h7A are stored minus 8'h20 (lowercase to uppercase), so soft-masked bases reach the compressor as A/C/G/T/N. Header, CR and LF handling are unchanged.
- Undefined: bytes are stored verbatim.

Test Plan:
- Reset then 100 bytes "ACGT" repeated, in_valid=1, line_ready=1 -> line_valid one cycle after the 100th byte; line_data[7:0]=8'h41, [15:8]=8'h43, [799:792]=8'h54; line_count=100; line_last=0.
- ">chr1 test\n" then "GATTACA\n" with in_last on the '\n' -> header fully dropped; one line with count=7, bytes 0..6="GATTACA", bytes 7..99=8'h41; line_last=1; stream_done pulse.
- 100 bases with line_ready=0 for 20 cycles -> in_ready=0 and line_data stable throughout; after line_ready=1 for one cycle, line_valid=0 next cycle and in_ready=1.
- 60 bases, "\r\n", 40 bases -> CR and LF dropped; a single line with count=100 spanning both input lines.
- 50 bases, then rst_n low for 1 cycle mid-stream -> outputs return to reset values immediately; no line emitted; next 100 bases produce a clean line with count=100.
- With GENE_CASE_FOLD_EN: "acgtn" + in_last -> bytes 0..4=8'h41,8'h43,8'h47,8'h54,8'h4E, count=5. Without the macro: bytes 0..4=8'h61,8'h63,8'h67,8'h74,8'h6E.
